cas_tape_recorder: RTL and testbench
====================================

// Module: cas_tape_recorder
// PURPOSE
//  Capture side of cassette support: decodes the TRS-80 500-baud cassette output pulse stream
//  (port FF bits 1:0, motor bit) into bytes and stores them in a byte buffer in CAS-file layout.
//  The buffer is then read out by the HPS upload path to produce a .CAS file.
//  Timing is measured in CPU T-states via cpu_ce, so all overclock settings decode identically.
// PARAMETERS
//  AW            12     buffer address width; capacity 2**AW bytes
//  LEADER_BYTES  255    0x00 bytes written ahead of the sync byte
//  DATA_MIN      1000   min T-states after clock pulse for a valid data pulse
//  DATA_MAX      2600   cell bit committed when the counter reaches DATA_MAX+1
//  GAP_MAX       20000  T-states with no clock pulse that end a recording
// PORTS
//  clk_sys      in   1     system clock
//  reset_n      in   1     asynchronous reset, active-low
//  cpu_ce       in   1     one-cycle pulse per CPU T-state
//  cass_out     in   2     cassette output level from the CPU port
//  cass_motor   in   1     cassette motor relay; 1 = on
//  clear        in   1     one-cycle: discard capture, return to IDLE
//  upl_addr     in   AW    upload read address
//  upl_data     out  8     upload read data, 1-cycle latency
//  cas_len      out  AW+1  bytes valid in buffer
//  recording    out  1     1 in FILL or DATA
//  data_ready   out  1     1 in DONE; capture complete
//  overflow     out  1     sticky; a write was dropped because the buffer was full
// BEHAVIOUR
//  - Reset: state IDLE, cas_len=0, recording=0, data_ready=0, overflow=0, upl_data=0. Buffer contents undefined.
//  - Pulse = cass_out goes from 2'b00 to nonzero (registered previous value; same clock domain).
//  - Cell counter cyc: 16 bits, increments on cpu_ce, saturates. On a pulse with cyc>DATA_MAX,
//    or with no cell open: pulse is a clock pulse; cyc<=0, cell opens, bit<=0.
//  - Pulse with cyc<DATA_MIN: ignored (glitch). Pulse with DATA_MIN<=cyc<=DATA_MAX: bit<=1;
//    repeated pulses in the window have no further effect.
//  - When cyc reaches DATA_MAX+1 in an open cell: bit shifts into sr[7:0] MSB-first; cell closes.
//  - States:
//    IDLE: cass_motor=1 -> HUNT.
//    HUNT: shift every committed bit; when sr==8'hA5 -> FILL. Motor off or cyc==GAP_MAX -> IDLE.
//    FILL: writes LEADER_BYTES 0x00 bytes, one per clk_sys, then 0xA5 -> DATA.
//      Bits are decoded concurrently into sr/bitcount; FILL lasts at most LEADER_BYTES+1 clocks,
//      much shorter than one cell, so no bit is lost.
//    DATA: every 8 committed bits, write sr at cas_len, cas_len++.
//      Motor off, or cyc==GAP_MAX with no open cell -> DONE. A partial byte is discarded.
//    DONE: holds; data_ready=1. clear -> IDLE; motor off->on without clear stays in DONE.
//  - Write with cas_len==2**AW: dropped; overflow<=1; the state machine continues normally.
//  - cas_len is cleared on entry to FILL. It is not cleared on HUNT->IDLE.
//  - clear: takes priority over any pulse or write in the same cycle.
//    Effect: IDLE, cas_len=0, overflow=0, cell closed, sr=0.
//  - Upload port: upl_data <= mem[upl_addr] every clk_sys.
//    A read of the address written in the same cycle returns the old data.
// STRUCTURE
//  - Package ht1080z_cas_pkg: state enum {IDLE,HUNT,FILL,DATA,DONE}; SYNC_BYTE=8'hA5.
//  - Sub-module cas_buffer_ram: simple dual-port 2**AW x 8.
//    Write port driven by this FSM; registered read port drives upl_*.
//  - Top holds the pulse detector, cell counter/bit decoder, FSM and length counter.
// TESTING
//  1. Reset asserted then released, no stimulus -> cas_len=0, recording=0, data_ready=0, overflow=0.
//  2. Motor on; 40 zero cells; A5, 55, C3 (cell period 3550 T-states, data pulse at 1774); motor off
//     -> cas_len=258; mem[0..254]=00, mem[255]=A5, mem[256]=55, mem[257]=C3; data_ready=1.
//  3. Extra pulse at cyc=200 and a second data pulse at cyc=2000 in the same cell
//     -> decoded bytes unchanged from scenario 2.
//  4. Motor held on after the last byte C3 -> DONE exactly GAP_MAX T-states after the last clock pulse.
//     The final bit is committed and cas_len=258.
//  5. AW=4, LEADER_BYTES=4; sync + 20 data bytes -> cas_len=16, overflow=1;
//     mem[4]=A5, mem[15]=11th data byte.
//  6. Pulse arrives in the same cycle as clear while in DATA -> IDLE, cas_len=0.
//     reset_n low mid-FILL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cas_tape_recorder_pkg.sv
// Shared types for the cassette capture path: FSM state encoding and the CAS sync byte.
package ht1080z_cas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        FILL,
        DATA,
        DONE
    } cas_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/cas_tape_recorder_if.sv
// Upload/status bundle between the tape recorder (slave) and the HPS upload path (master).
interface cas_tape_recorder_if #(
    parameter int AW = 12
);
    // Plain read port: upl_data follows upl_addr one clk_sys later; no handshake.
    logic [AW-1:0] upl_addr;
    logic [7:0]    upl_data;
    logic [AW:0]   cas_len;
    logic          recording;
    logic          data_ready;
    logic          overflow;

    modport master (
        output upl_addr,
        input  upl_data, cas_len, recording, data_ready, overflow
    );

    modport slave (
        input  upl_addr,
        output upl_data, cas_len, recording, data_ready, overflow
    );
endinterface

// File: rtl/cas_tape_recorder_ram.sv
// Simple dual-port byte buffer: one write port, one registered read port (old data on collision).
module cas_buffer_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/cas_tape_recorder.sv
// Cassette capture: measures pulse spacing in CPU T-states, decodes 500-baud cells into
// bytes and stores leader + sync + data in CAS-file layout for upload.
module cas_tape_recorder
    import ht1080z_cas_pkg::*;
#(
    parameter int AW           = 12,
    parameter int LEADER_BYTES = 255,
    parameter int DATA_MIN     = 1000,
    parameter int DATA_MAX     = 2600,
    parameter int GAP_MAX      = 20000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               cpu_ce,
    input  logic [1:0]         cass_out,
    input  logic               cass_motor,
    input  logic               clear,
    cas_tape_recorder_if.slave upl,
    output cas_state_t         dbg_state
);
    localparam int LW = AW + 1;
    localparam int FW = (LEADER_BYTES > 0) ? $clog2(LEADER_BYTES + 1) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(LEADER_BYTES);
    localparam logic [LW-1:0] CAPACITY  = {1'b1, {AW{1'b0}}};
    localparam logic [15:0]   C_MIN     = 16'(DATA_MIN);
    localparam logic [15:0]   C_MAX     = 16'(DATA_MAX);
    localparam logic [15:0]   C_COMMIT  = 16'(DATA_MAX + 1);
    localparam logic [15:0]   C_GAP     = 16'(GAP_MAX);

    cas_state_t    state;
    logic [1:0]    prev_out;
    logic [15:0]   cyc;
    logic          cell_open;
    logic          bit_val;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt;
    logic [LW-1:0] cas_len;
    logic [FW-1:0] fill_cnt;
    logic          recording;
    logic          data_ready;
    logic          overflow;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    logic          pulse;
    logic          clock_pulse;
    logic          data_pulse;
    logic          commit;
    logic          sync_hit;
    logic [7:0]    new_byte;
    logic          wr_req;
    logic [7:0]    wr_byte;

    // A pulse only counts on the 00 -> nonzero transition of the port level.
    assign pulse       = (prev_out == 2'b00) && (cass_out != 2'b00);
    assign clock_pulse = pulse && (!cell_open || (cyc > C_MAX));
    assign data_pulse  = pulse && cell_open && (cyc >= C_MIN) && (cyc <= C_MAX);
    assign commit      = cell_open && (cyc == C_COMMIT);
    assign new_byte    = {sr[6:0], bit_val};
    assign sync_hit    = (state == HUNT) && cass_motor && (sr == SYNC_BYTE);

    always_ff @(posedge clk_sys or negedge reset_n) begin : decoder
        if (!reset_n) begin
            prev_out  <= 2'b00;
            cyc       <= 16'h0000;
            cell_open <= 1'b0;
            bit_val   <= 1'b0;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
        end else begin
            prev_out <= cass_out;
            if (clock_pulse && !clear) begin
                cyc <= 16'h0000;
            end else if (cpu_ce && (cyc != 16'hFFFF)) begin
                cyc <= cyc + 16'd1;
            end

            if (clear) begin
                cell_open <= 1'b0;
                bit_val   <= 1'b0;
                sr        <= 8'h00;
                bit_cnt   <= 3'd0;
            end else begin
                if (commit) begin
                    sr      <= new_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                // Realign byte framing to the sync byte just found.
                if (sync_hit) begin
                    bit_cnt <= 3'd0;
                end
                if (clock_pulse) begin
                    cell_open <= 1'b1;
                    bit_val   <= 1'b0;
                end else if (commit) begin
                    cell_open <= 1'b0;
                end else if (data_pulse) begin
                    bit_val <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_req  = 1'b0;
        wr_byte = 8'h00;
        if (!clear) begin
            if (state == FILL) begin
                wr_req  = 1'b1;
                wr_byte = (fill_cnt == FILL_LAST) ? SYNC_BYTE : 8'h00;
            end else if ((state == DATA) && cass_motor && commit && (bit_cnt == 3'd7)) begin
                wr_req  = 1'b1;
                wr_byte = new_byte;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin : fsm
        if (!reset_n) begin
            state      <= IDLE;
            cas_len    <= '0;
            fill_cnt   <= '0;
            recording  <= 1'b0;
            data_ready <= 1'b0;
            overflow   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                cas_len    <= '0;
                overflow   <= 1'b0;
                recording  <= 1'b0;
                data_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cass_motor) begin
                            state <= HUNT;
                        end
                    end
                    HUNT: begin
                        if (sync_hit) begin
                            state     <= FILL;
                            recording <= 1'b1;
                            cas_len   <= '0;
                            fill_cnt  <= '0;
                        end else if (!cass_motor || (cyc == C_GAP)) begin
                            state <= IDLE;
                        end
                    end
                    FILL: begin
                        if (fill_cnt == FILL_LAST) begin
                            state <= DATA;
                        end else begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                    DATA: begin
                        if (!cass_motor || ((cyc == C_GAP) && !cell_open)) begin
                            state      <= DONE;
                            recording  <= 1'b0;
                            data_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase

                // Writes land in the RAM one clock later; a full buffer drops them.
                if (wr_req) begin
                    if (cas_len == CAPACITY) begin
                        overflow <= 1'b1;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= cas_len[AW-1:0];
                        wr_data <= wr_byte;
                        cas_len <= cas_len + LW'(1);
                    end
                end
            end
        end
    end

    cas_buffer_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (upl.upl_addr),
        .rdata (upl.upl_data)
    );

    assign upl.cas_len    = cas_len;
    assign upl.recording  = recording;
    assign upl.data_ready = data_ready;
    assign upl.overflow   = overflow;
    assign dbg_state      = state;
endmodule

// File: tb/tb_cas_tape_recorder.sv
// Directed bench for cas_tape_recorder: a full-size instance and a tiny AW=4 instance
// share the cassette line; cell timing is scaled down to keep the run short.
module tb_cas_tape_recorder;
    import ht1080z_cas_pkg::*;

    // Main instance: window 100..260, gap 2000, cell 355 T-states, data pulse at 177.
    localparam int M_MIN = 100, M_MAX = 260, M_GAP = 2000, M_PER = 355, M_OFF = 177;
    // Small instance: window 20..52, gap 400, cell 71 T-states, data pulse at 35.
    localparam int S_MIN = 20, S_MAX = 52, S_GAP = 400, S_PER = 71, S_OFF = 35;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       cpu_ce   = 1'b0;
    logic [1:0] cass_out = 2'b00;
    logic       motor_m  = 1'b0;
    logic       motor_s  = 1'b0;
    logic       clear_m  = 1'b0;
    logic       clear_s  = 1'b0;
    cas_state_t st_m;
    cas_state_t st_s;

    cas_tape_recorder_if #(.AW(12)) upl_m ();
    cas_tape_recorder_if #(.AW(4))  upl_s ();

    cas_tape_recorder #(
        .AW(12), .LEADER_BYTES(255), .DATA_MIN(M_MIN), .DATA_MAX(M_MAX), .GAP_MAX(M_GAP)
    ) dut_m (
        .clk_sys(clk_sys), .reset_n(reset_n), .cpu_ce(cpu_ce), .cass_out(cass_out),
        .cass_motor(motor_m), .clear(clear_m), .upl(upl_m), .dbg_state(st_m)
    );

    cas_tape_recorder #(
        .AW(4), .LEADER_BYTES(4), .DATA_MIN(S_MIN), .DATA_MAX(S_MAX), .GAP_MAX(S_GAP)
    ) dut_s (
        .clk_sys(clk_sys), .reset_n(reset_n), .cpu_ce(cpu_ce), .cass_out(cass_out),
        .cass_motor(motor_s), .clear(clear_s), .upl(upl_s), .dbg_state(st_s)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ce_div   = 1;
    int per      = M_PER;
    int off      = M_OFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One T-state: cpu_ce on the first clock, then ce_div-1 idle clocks.
    task automatic tick(input logic [1:0] lvl);
        cass_out = lvl;
        cpu_ce   = 1'b1;
        @(posedge clk_sys); #1;
        cpu_ce = 1'b0;
        for (int i = 1; i < ce_div; i++) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic idle_t(input int n);
        for (int i = 0; i < n; i++) tick(2'b00);
    endtask

    // Clock pulse at T 0..3, data pulse at off; noisy adds a glitch at 20 and a repeat at 200.
    task automatic send_cell(input bit b, input bit noisy);
        for (int t = 0; t < per; t++) begin
            logic [1:0] lvl;
            lvl = 2'b00;
            if (t < 4) lvl = 2'b01;
            if (b && t >= off && t < off + 4) lvl = 2'b10;
            if (noisy && t >= 20 && t < 24) lvl = 2'b11;
            if (noisy && b && t >= 200 && t < 204) lvl = 2'b01;
            tick(lvl);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit noisy);
        for (int i = 7; i >= 0; i--) send_cell(v[i], noisy);
    endtask

    task automatic check_mem_m(input string tag, input int addr, input logic [7:0] exp);
        upl_m.upl_addr = 12'(addr);
        @(posedge clk_sys); #1;
        check(tag, 32'(upl_m.upl_data), 32'(exp));
    endtask

    task automatic check_mem_s(input string tag, input int addr, input logic [7:0] exp);
        upl_s.upl_addr = 4'(addr);
        @(posedge clk_sys); #1;
        check(tag, 32'(upl_s.upl_data), 32'(exp));
    endtask

    initial begin
        upl_m.upl_addr = '0;
        upl_s.upl_addr = '0;

        // Reset held, then released with no stimulus.
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_len", 32'(upl_m.cas_len), 0);
        check("rst_rec", 32'(upl_m.recording), 0);
        check("rst_rdy", 32'(upl_m.data_ready), 0);
        check("rst_ovf", 32'(upl_m.overflow), 0);
        check("rst_upl", 32'(upl_m.upl_data), 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
        check("idle_state", 32'(st_m), 32'(IDLE));
        check("idle_len", 32'(upl_m.cas_len), 0);
        check("idle_rdy", 32'(upl_m.data_ready), 0);

        // Clean recording: 40 zero cells, A5 55 C3, motor off.
        motor_m = 1'b1;
        repeat (40) send_cell(1'b0, 1'b0);
        send_byte(8'hA5, 1'b0);
        check("s2_fill", 32'(st_m), 32'(FILL));
        check("s2_rec", 32'(upl_m.recording), 1);
        send_byte(8'h55, 1'b0);
        check("s2_len_mid", 32'(upl_m.cas_len), 257);
        send_byte(8'hC3, 1'b0);
        motor_m = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        check("s2_done", 32'(st_m), 32'(DONE));
        check("s2_rdy", 32'(upl_m.data_ready), 1);
        check("s2_rec_off", 32'(upl_m.recording), 0);
        check("s2_len", 32'(upl_m.cas_len), 258);
        check("s2_ovf", 32'(upl_m.overflow), 0);
        check_mem_m("s2_mem0", 0, 8'h00);
        check_mem_m("s2_mem254", 254, 8'h00);
        check_mem_m("s2_mem255", 255, 8'hA5);
        check_mem_m("s2_mem256", 256, 8'h55);
        check_mem_m("s2_mem257", 257, 8'hC3);

        // Noisy cells, motor held on: gap timeout must end the capture.
        clear_m = 1'b1;
        @(posedge clk_sys); #1;
        clear_m = 1'b0;
        check("clr_state", 32'(st_m), 32'(IDLE));
        check("clr_len", 32'(upl_m.cas_len), 0);
        check("clr_rdy", 32'(upl_m.data_ready), 0);
        motor_m = 1'b1;
        repeat (4) send_cell(1'b0, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'hC3, 1'b1);
        // Last clock pulse was T 0 of the final cell; DONE registers one clock after cyc==GAP.
        idle_t(M_GAP - M_PER + 1);
        check("gap_not_yet", 32'(st_m), 32'(DATA));
        check("gap_rdy_0", 32'(upl_m.data_ready), 0);
        tick(2'b00);
        check("gap_done", 32'(st_m), 32'(DONE));
        check("gap_rdy_1", 32'(upl_m.data_ready), 1);
        check("gap_len", 32'(upl_m.cas_len), 258);
        check_mem_m("noisy_mem255", 255, 8'hA5);
        check_mem_m("noisy_mem256", 256, 8'h55);
        check_mem_m("noisy_mem257", 257, 8'hC3);
        motor_m = 1'b0;
        idle_t(3);
        motor_m = 1'b1;
        idle_t(3);
        check("done_hold", 32'(st_m), 32'(DONE));

        // Small buffer: 4 leader bytes, sync, 20 data bytes 01..14.
        ce_div = 2;
        per    = S_PER;
        off    = S_OFF;
        clear_s = 1'b1;
        @(posedge clk_sys); #1;
        clear_s = 1'b0;
        motor_s = 1'b1;
        send_byte(8'hA5, 1'b0);
        for (int i = 1; i <= 11; i++) send_byte(8'(i), 1'b0);
        check("ovf_full_len", 32'(upl_s.cas_len), 16);
        check("ovf_not_yet", 32'(upl_s.overflow), 0);
        send_byte(8'd12, 1'b0);
        check("ovf_set", 32'(upl_s.overflow), 1);
        check("ovf_len_held", 32'(upl_s.cas_len), 16);
        check("ovf_still_data", 32'(st_s), 32'(DATA));
        for (int i = 13; i <= 20; i++) send_byte(8'(i), 1'b0);
        motor_s = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        check("ovf_done", 32'(st_s), 32'(DONE));
        check("ovf_len_end", 32'(upl_s.cas_len), 16);
        check("ovf_sticky", 32'(upl_s.overflow), 1);
        check_mem_s("ovf_mem3", 3, 8'h00);
        check_mem_s("ovf_mem4", 4, 8'hA5);
        check_mem_s("ovf_mem5", 5, 8'h01);
        check_mem_s("ovf_mem15", 15, 8'h0B);

        // Clear coinciding with a clock pulse while in DATA.
        ce_div = 1;
        per    = M_PER;
        off    = M_OFF;
        clear_m = 1'b1;
        @(posedge clk_sys); #1;
        clear_m = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_cell(1'b1, 1'b0);
        send_cell(1'b0, 1'b0);
        send_cell(1'b1, 1'b0);
        check("c6_data", 32'(st_m), 32'(DATA));
        check("c6_len", 32'(upl_m.cas_len), 256);
        clear_m = 1'b1;
        tick(2'b01);
        clear_m = 1'b0;
        check("c6_idle", 32'(st_m), 32'(IDLE));
        check("c6_len0", 32'(upl_m.cas_len), 0);
        check("c6_rec0", 32'(upl_m.recording), 0);
        idle_t(4);

        // Asynchronous reset in the middle of FILL.
        send_byte(8'hA5, 1'b0);
        idle_t(10);
        check("r6_fill", 32'(st_m), 32'(FILL));
        #2 reset_n = 1'b0;
        #1;
        check("r6_state", 32'(st_m), 32'(IDLE));
        check("r6_len", 32'(upl_m.cas_len), 0);
        check("r6_rec", 32'(upl_m.recording), 0);
        check("r6_rdy", 32'(upl_m.data_ready), 0);
        check("r6_ovf_s", 32'(upl_s.overflow), 0);
        check("r6_rdy_s", 32'(upl_s.data_ready), 0);
        check("r6_upl_s", 32'(upl_s.upl_data), 0);
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
